// File: rtl/load_store_unit_if.sv
// Request/response and memory-port bundle for the load/store unit.
// The slave modport is the LSU; the master side is the datapath plus memory.
interface load_store_unit_if #(
    parameter int unsigned ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_wdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [63:0]       resp_rdata;
    logic              resp_err;

    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic              mem_wr;
    logic [63:0]       mem_rdata;

    logic              busy;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_wdata, mem_wr, busy
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_wdata, mem_wr, busy
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word/dword accesses onto a doubleword-aligned memory
// port, with read-modify-write for sub-doubleword stores and misalignment errors.
module load_store_unit #(
    parameter int unsigned ADDR_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    load_store_unit_if.slave      bus
);
    localparam int unsigned DATA_W = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_RESP
    } state_e;

    state_e              state_q;
    logic [2:0]          off_q;
    logic [1:0]          size_q;
    logic                we_q;
    logic                uns_q;
    logic [DATA_W-1:0]   wdata_q;

    logic                ready_q;
    logic                resp_valid_q;
    logic                resp_err_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                mem_wr_q;
    logic                busy_q;

    logic                misaligned_c;
    logic [5:0]          bit_off_c;
    logic [DATA_W-1:0]   lane_c;
    logic [DATA_W-1:0]   load_c;
    logic [DATA_W-1:0]   size_mask_c;
    logic [DATA_W-1:0]   merge_c;

    always_comb begin
        unique case (bus.req_size)
            2'd0:    misaligned_c = 1'b0;
            2'd1:    misaligned_c = bus.req_addr[0];
            2'd2:    misaligned_c = |bus.req_addr[1:0];
            default: misaligned_c = |bus.req_addr[2:0];
        endcase
    end

    // Extract/extend the load field and merge store bytes into the fetched dword.
    always_comb begin
        bit_off_c   = {off_q, 3'b000};
        lane_c      = bus.mem_rdata >> bit_off_c;
        load_c      = lane_c;
        size_mask_c = {DATA_W{1'b1}};
        unique case (size_q)
            2'd0: begin
                load_c      = uns_q ? {{(DATA_W-8){1'b0}}, lane_c[7:0]}
                                    : {{(DATA_W-8){lane_c[7]}}, lane_c[7:0]};
                size_mask_c = DATA_W'(64'h0000_0000_0000_00FF);
            end
            2'd1: begin
                load_c      = uns_q ? {{(DATA_W-16){1'b0}}, lane_c[15:0]}
                                    : {{(DATA_W-16){lane_c[15]}}, lane_c[15:0]};
                size_mask_c = DATA_W'(64'h0000_0000_0000_FFFF);
            end
            2'd2: begin
                load_c      = uns_q ? {{(DATA_W-32){1'b0}}, lane_c[31:0]}
                                    : {{(DATA_W-32){lane_c[31]}}, lane_c[31:0]};
                size_mask_c = DATA_W'(64'h0000_0000_FFFF_FFFF);
            end
            default: begin
                load_c      = lane_c;
                size_mask_c = {DATA_W{1'b1}};
            end
        endcase
        merge_c = (bus.mem_rdata & ~(size_mask_c << bit_off_c))
                | ((wdata_q & size_mask_c) << bit_off_c);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            off_q        <= 3'd0;
            size_q       <= 2'd0;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            wdata_q      <= '0;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wr_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (ready_q && bus.req_valid) begin
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        off_q   <= bus.req_addr[2:0];
                        size_q  <= bus.req_size;
                        we_q    <= bus.req_we;
                        uns_q   <= bus.req_unsigned;
                        wdata_q <= bus.req_wdata;
                        if (misaligned_c) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else begin
                            mem_addr_q <= {bus.req_addr[ADDR_W-1:3], 3'b000};
                            if (bus.req_we && (bus.req_size == 2'd3)) begin
                                state_q     <= S_WR;
                                mem_wr_q    <= 1'b1;
                                mem_wdata_q <= bus.req_wdata;
                            end else begin
                                state_q <= S_RD;
                            end
                        end
                    end
                end
                S_RD: state_q <= S_CAP;
                S_CAP: begin
                    if (we_q) begin
                        state_q     <= S_WR;
                        mem_wr_q    <= 1'b1;
                        mem_wdata_q <= merge_c;
                    end else begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        rdata_q      <= load_c;
                    end
                end
                S_WR: begin
                    state_q      <= S_RESP;
                    mem_wr_q     <= 1'b0;
                    resp_valid_q <= 1'b1;
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        state_q      <= S_IDLE;
                        ready_q      <= 1'b1;
                        busy_q       <= 1'b0;
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        rdata_q      <= '0;
                        mem_addr_q   <= '0;
                        mem_wdata_q  <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_wr     = mem_wr_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array reference memory, directed cases with
// literal expectations, then randomized loads/stores with response stalls.
module tb_load_store_unit;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    load_store_unit_if #(.ADDR_W(64)) bus ();
    load_store_unit #(.ADDR_W(64)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [63:0] mem_arr [0:7];
    logic [7:0]  ref_mem [0:63];
    logic [63:0] exp_maddr;
    logic [63:0] exp_mwdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: registered read, one-cycle latency; write on the edge where mem_wr is high.
    always @(posedge clk) begin
        bus.mem_rdata <= mem_arr[bus.mem_addr[5:3]];
        if (bus.mem_wr) mem_arr[bus.mem_addr[5:3]] <= bus.mem_wdata;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp_v);
        end
    endtask

    function automatic logic [63:0] ref_dword(input int a);
        logic [63:0] d = '0;
        for (int k = 0; k < 8; k++) d[8*k +: 8] = ref_mem[(a & 56) + k];
        return d;
    endfunction

    function automatic logic [63:0] model_load(input int a, input int n, input bit uns);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[a + i];
        if (!uns && n < 8 && v[8*n-1]) v = v | ({64{1'b1}} << (8*n));
        return v;
    endfunction

    function automatic logic [63:0] store_preview(input int a, input int n, input logic [63:0] wd);
        logic [7:0]  b [0:7];
        logic [63:0] d = '0;
        for (int k = 0; k < 8; k++) b[k] = ref_mem[(a & 56) + k];
        for (int i = 0; i < n; i++) b[(a & 7) + i] = wd[8*i +: 8];
        for (int k = 0; k < 8; k++) d[8*k +: 8] = b[k];
        return d;
    endfunction

    // Cycle-by-cycle checks on the memory port and idle handshake.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.mem_wr) begin
                chk("mon_mem_addr", bus.mem_addr, exp_maddr);
                chk("mon_mem_wdata", bus.mem_wdata, exp_mwdata);
                chk("mon_busy_in_wr", 64'(bus.busy), 64'd1);
            end
            if (bus.req_ready) chk("mon_ready_idle", 64'({bus.busy, bus.resp_valid, bus.mem_wr}), 64'd0);
        end
    end

    task automatic drive_req(input bit we, input logic [1:0] size, input bit uns,
                             input logic [63:0] addr, input logic [63:0] wdata);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
    endtask

    task automatic scramble_req();
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'($urandom);
        bus.req_size     = 2'($urandom);
        bus.req_unsigned = 1'($urandom);
        bus.req_addr     = {$urandom, $urandom};
        bus.req_wdata    = {$urandom, $urandom};
    endtask

    task automatic wait_ready(output bit ok);
        int g = 0;
        while (!bus.req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        ok = bus.req_ready;
        if (!ok) chk("req_ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_req(input bit we, input logic [1:0] size, input bit uns,
                          input logic [63:0] addr, input logic [63:0] wdata, input int stall,
                          output logic [63:0] got_rdata, output int got_lat);
        int          n;
        int          a;
        bit          mis;
        bit          ok;
        int          e_lat;
        int          wr_seen;
        logic [63:0] e_rdata;
        logic        got_err;
        n   = 1 << size;
        a   = int'(addr[5:0]);
        mis = (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0) ||
              (size == 2'd3 && addr[2:0] != 3'd0);
        e_rdata    = (mis || we) ? 64'd0 : model_load(a, n, uns);
        e_lat      = mis ? 1 : (!we ? 3 : (size == 2'd3 ? 2 : 4));
        exp_maddr  = {addr[63:3], 3'b000};
        exp_mwdata = store_preview(a, n, wdata);
        got_rdata  = '0;
        got_lat    = 0;

        drive_req(we, size, uns, addr, wdata);
        wait_ready(ok);
        if (!ok) begin
            bus.req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        scramble_req();
        got_lat = 1;
        wr_seen = 0;
        while (!bus.resp_valid && got_lat < 8) begin
            if (!mis) chk("mem_addr_busy", bus.mem_addr, exp_maddr);
            if (bus.mem_wr) wr_seen++;
            @(negedge clk);
            got_lat++;
        end
        if (!bus.resp_valid) begin
            chk("resp_timeout", 64'd0, 64'd1);
            bus.resp_ready = 1'b1;
            @(negedge clk);
            bus.resp_ready = 1'b0;
            return;
        end
        got_rdata = bus.resp_rdata;
        got_err   = bus.resp_err;
        chk("latency", 64'(got_lat), 64'(e_lat));
        chk("resp_err", 64'(got_err), 64'(mis));
        chk("resp_rdata", got_rdata, e_rdata);
        chk("wr_pulses", 64'(wr_seen), 64'(we && !mis));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_hold", {bus.resp_rdata[62:0], bus.resp_err}, {got_rdata[62:0], got_err});
            chk("stall_flags", 64'({bus.resp_valid, bus.req_ready, bus.mem_wr}), 64'b100);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        chk("after_resp", 64'({bus.resp_valid, bus.busy, bus.req_ready}), 64'b001);
        if (we && !mis) for (int i = 0; i < n; i++) ref_mem[a + i] = wdata[8*i +: 8];
        chk("mem_dword", mem_arr[a >> 3], ref_dword(a));
    endtask

    initial begin
        logic [63:0] got;
        int          lat;
        bit          ok;
        logic [63:0] init;
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.resp_ready = 1'b0;
        exp_maddr = '0;
        exp_mwdata = '0;
        for (int d = 0; d < 8; d++) begin
            init = {$urandom, $urandom};
            if (d == 2) init = 64'h8877665544332211;
            mem_arr[d] = init;
            for (int k = 0; k < 8; k++) ref_mem[8*d + k] = init[8*k +: 8];
        end

        #3;
        chk("rst_flags", 64'({bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_wr, bus.busy}), 64'd0);
        chk("rst_rdata", bus.resp_rdata, 64'd0);
        chk("rst_mem_addr", bus.mem_addr, 64'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        do_req(1'b0, 2'd0, 1'b0, 64'h17, 64'd0, 0, got, lat);
        chk("lit_lb_rdata", got, 64'hFFFF_FFFF_FFFF_FF88);
        chk("lit_lb_lat", 64'(lat), 64'd3);
        do_req(1'b0, 2'd0, 1'b1, 64'h17, 64'd0, 1, got, lat);
        chk("lit_lbu_rdata", got, 64'h88);
        do_req(1'b1, 2'd1, 1'b0, 64'h12, 64'hABCD, 0, got, lat);
        chk("lit_sh_mem", mem_arr[2], 64'h8877_6655_ABCD_2211);
        chk("lit_sh_lat", 64'(lat), 64'd4);
        do_req(1'b0, 2'd2, 1'b0, 64'h16, 64'd0, 0, got, lat);
        chk("lit_lw_mis_rdata", got, 64'd0);
        chk("lit_lw_mis_lat", 64'(lat), 64'd1);
        do_req(1'b1, 2'd3, 1'b0, 64'h18, 64'h0123_4567_89AB_CDEF, 3, got, lat);
        chk("lit_sd_mem", mem_arr[3], 64'h0123_4567_89AB_CDEF);
        chk("lit_sd_lat", 64'(lat), 64'd2);

        // Store byte aborted by reset while its write cycle is on the memory port.
        exp_maddr  = 64'h20;
        exp_mwdata = store_preview(33, 1, 64'h5A);
        drive_req(1'b1, 2'd0, 1'b0, 64'h21, 64'h5A);
        wait_ready(ok);
        if (ok) begin
            @(negedge clk);
            scramble_req();
            repeat (2) @(negedge clk);
            chk("sb_in_wr", 64'(bus.mem_wr), 64'd1);
            #2 rst = 1'b0;
            #1;
            chk("rst_mid_wr", 64'({bus.mem_wr, bus.busy, bus.req_ready, bus.resp_valid}), 64'd0);
            @(negedge clk);
            chk("rst_mem_kept", mem_arr[4], ref_dword(32));
        end
        bus.req_valid = 1'b0;
        rst = 1'b1;
        do_req(1'b0, 2'd1, 1'b1, 64'h20, 64'd0, 0, got, lat);
        chk("post_rst_lhu", got, 64'(ref_dword(32) & 64'hFFFF));

        for (int t = 0; t < 300; t++) begin
            do_req(1'($urandom), 2'($urandom), 1'($urandom), {$urandom, $urandom},
                   {$urandom, $urandom}, int'($urandom_range(0, 3)), got, lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
